// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared types and helpers for the multi-channel edge detector
package edge_detect_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_e;

    localparam int unsigned MAX_CNT_W = 32;

    function automatic logic mode_hit(edge_mode_e mode, logic rise, logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
// rtl/edge_detect_multi_if.sv - per-channel input/status bundle of the edge detector
interface edge_detect_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    import edge_detect_pkg::*;

    logic       [N_CH-1:0]            sig;
    edge_mode_e [N_CH-1:0]            mode;
    logic       [N_CH-1:0]            clr;
    logic       [N_CH-1:0]            pulse;
    logic       [N_CH-1:0]            pending;
    logic       [N_CH-1:0]            level;
    logic       [N_CH-1:0][CNT_W-1:0] count;

    modport master (output sig, mode, clr, input pulse, pending, level, count);
    modport slave  (input sig, mode, clr, output pulse, pending, level, count);

endinterface

// File: rtl/edge_detect_chan.sv
// rtl/edge_detect_chan.sv - one channel: sync, debounce (EDGE_DEBOUNCE_EN), detect, stretch, pending, count
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
`ifdef EDGE_DEBOUNCE_EN
    parameter int DEB_CYCLES  = 4,
`endif
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed_i,
    input  logic             sig_i,
    input  edge_mode_e       mode_i,
    input  logic             clr_i,
    output logic             pulse_o,
    output logic             pending_o,
    output logic             level_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int               STR_W   = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt;
    logic                   prev_q;
    logic                   det_q, det_d;
    logic [STR_W-1:0]       str_q, str_d;
    logic                   pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = sig_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_q, deb_d;
    logic             filt_q, filt_d;

    // Any cycle where the synced input agrees with filt restarts the window.
    always_comb begin
        deb_d  = '0;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            deb_q  <= deb_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    // Detection is registered once; stretch, pending and count all act on det_q together.
    always_comb begin
        det_d = armed_i & mode_hit(mode_i, filt & ~prev_q, ~filt & prev_q);

        str_d = str_q;
        if (det_q) begin
            str_d = STR_W'(PULSE_LEN);
        end else if (str_q != '0) begin
            str_d = str_q - 1'b1;
        end

        pending_d = det_q | (pending_q & ~clr_i);

        count_d = count_q;
        if (det_q) begin
            count_d = clr_i ? CNT_W'(1) : ((count_q == CNT_MAX) ? count_q : count_q + 1'b1);
        end else if (clr_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            det_q     <= 1'b0;
            str_q     <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= filt;
            det_q     <= det_d;
            str_q     <= str_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pulse_o   = (str_q != '0);
    assign pending_o = pending_q;
    assign level_o   = filt;
    assign count_o   = count_q;

endmodule

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - N-channel edge detector top with shared arm counter; EDGE_DEBOUNCE_EN adds debounce
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    edge_detect_multi_if.slave io
);
`ifdef EDGE_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    // The window covers the filter latency so a level already present at reset release never counts.
    localparam int ARM_LEN = SYNC_STAGES + 1 + (DEB_EN ? DEB_CYCLES : 0);
    localparam int ARM_W   = $clog2(ARM_LEN + 1);

    logic [ARM_W-1:0] arm_q, arm_d;
    logic             armed;

    assign armed = (arm_q == ARM_W'(ARM_LEN));
    assign arm_d = armed ? arm_q : arm_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= '0;
        end else begin
            arm_q <= arm_d;
        end
    end

    logic [N_CH-1:0]            pulse_w;
    logic [N_CH-1:0]            pending_w;
    logic [N_CH-1:0]            level_w;
    logic [N_CH-1:0][CNT_W-1:0] count_w;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_detect_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN),
`ifdef EDGE_DEBOUNCE_EN
            .DEB_CYCLES  (DEB_CYCLES),
`endif
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .armed_i   (armed),
            .sig_i     (io.sig[g]),
            .mode_i    (io.mode[g]),
            .clr_i     (io.clr[g]),
            .pulse_o   (pulse_w[g]),
            .pending_o (pending_w[g]),
            .level_o   (level_w[g]),
            .count_o   (count_w[g])
        );
    end

    assign io.pulse   = pulse_w;
    assign io.pending = pending_w;
    assign io.level   = level_w;
    assign io.count   = count_w;

endmodule
